// File: rtl/logic16_arbiter_pkg.sv
// Shared constants for the two-requester bitwise logic arbiter:
// opcode encoding, FSM state encoding and the default datapath width.
package logic16_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic16_arbiter_if.sv
// One requester's command channel plus its response channel.
// The requester side uses the master modport, the arbiter the slave modport.
interface logic16_arbiter_if
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/logic16_arbiter_unit.sv
// Combinational bitwise logic unit: per-bit gate instances for NOT/AND/OR/XOR,
// followed by an opcode select. Operand b is ignored for NOT.
module logic16_unit
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_out
);
    logic [WIDTH-1:0] w_not;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            not u_not (w_not[gi], i_a[gi]);
            and u_and (w_and[gi], i_a[gi], i_b[gi]);
            or  u_or  (w_or[gi],  i_a[gi], i_b[gi]);
            xor u_xor (w_xor[gi], i_a[gi], i_b[gi]);
        end
    endgenerate

    // Select the gate bank named by the opcode
    always_comb begin
        o_out = w_not;
        case (i_op)
            OP_NOT:  o_out = w_not;
            OP_AND:  o_out = w_and;
            OP_OR:   o_out = w_or;
            OP_XOR:  o_out = w_xor;
            default: o_out = w_not;
        endcase
    end
endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one logic16_unit between two requesters.
// One transaction in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold
// result until the owner takes it). The owner's priority passes to the other
// requester when its response completes.
module logic16_arbiter
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    logic16_arbiter_if.slave    req0,
    logic16_arbiter_if.slave    req1,
    output logic                busy
);
    state_e           r_state;
    state_e           w_state_next;
    logic             r_prio;
    logic             r_owner;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp0_data;
    logic [WIDTH-1:0] r_rsp1_data;
    logic [WIDTH-1:0] w_result;

    logic w_grant0;
    logic w_grant1;
    logic w_ready0;
    logic w_ready1;
    logic w_accept;
    logic w_rsp_done;

    // When both ask, r_prio picks the winner; a lone requester always wins
    assign w_grant0   = req0.req_valid && (!req1.req_valid || !r_prio);
    assign w_grant1   = req1.req_valid && (!req0.req_valid ||  r_prio);
    assign w_ready0   = (r_state == IDLE) && w_grant0;
    assign w_ready1   = (r_state == IDLE) && w_grant1;
    assign w_accept   = w_ready0 || w_ready1;
    assign w_rsp_done = (r_state == RESP) &&
                        (r_owner ? req1.rsp_ready : req0.rsp_ready);

    assign req0.req_ready = w_ready0;
    assign req1.req_ready = w_ready1;
    assign req0.rsp_valid = (r_state == RESP) && !r_owner;
    assign req1.rsp_valid = (r_state == RESP) &&  r_owner;
    assign req0.rsp_data  = r_rsp0_data;
    assign req1.rsp_data  = r_rsp1_data;
    assign busy           = (r_state != IDLE);

    logic16_unit #(.WIDTH(WIDTH)) u_unit (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_out (w_result)
    );

    // Next-state logic for the IDLE/EXEC/RESP sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_next = EXEC;
            EXEC:                    w_state_next = RESP;
            RESP:    if (w_rsp_done) w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Capture the winning command on its handshake edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 2'b00;
            r_a     <= '0;
            r_b     <= '0;
            r_owner <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_ready1;
            r_op    <= w_ready1 ? req1.req_op : req0.req_op;
            r_a     <= w_ready1 ? req1.req_a  : req0.req_a;
            r_b     <= w_ready1 ? req1.req_b  : req0.req_b;
        end
    end

    // Register the result into the owner's response data; the other side holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_data <= '0;
            r_rsp1_data <= '0;
        end else if (r_state == EXEC) begin
            if (r_owner) r_rsp1_data <= w_result;
            else         r_rsp0_data <= w_result;
        end
    end

    // Hand priority to the non-owner once the response is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_prio <= 1'b0;
        else if (w_rsp_done) r_prio <= !r_owner;
    end
endmodule
